// File: rtl/sd_pkg.sv
// Shared definitions for the sphere-decoder front end: R-element geometry,
// beat/slot mapping and the controller state encoding.
package sd_pkg;

  // Number of upper-triangular R elements for an NT x NT channel.
  function automatic int calc_nre(input int nt);
    return nt * (nt + 1) / 2;
  endfunction

  // Beats needed to carry all R elements at NT elements per beat.
  function automatic int calc_rbeats(input int nt);
    return (calc_nre(nt) + nt - 1) / nt;
  endfunction

  // Beat that carries R element e.
  function automatic int elem_beat(input int e, input int nt);
    return e / nt;
  endfunction

  // Slot within its beat that carries R element e.
  function automatic int elem_slot(input int e, input int nt);
    return e % nt;
  endfunction

  typedef enum logic [1:0] {
    NOCHAN = 2'd0,
    LOAD_R = 2'd1,
    IDLE   = 2'd2,
    RUN    = 2'd3
  } sd_state_e;

endpackage

// File: rtl/sd_r_loader.sv
// Multi-beat loader for the upper-triangular channel R: tracks the beat
// position, scatters slots into the element register file and flags when a
// complete channel is held.
module sd_r_loader
  import sd_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NT    = 4,
  localparam int NRE    = calc_nre(NT),
  localparam int RBEATS = calc_rbeats(NT)
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      r_we,       // accepted R beat
  input  logic                      r_first,    // beat starts a new channel
  input  logic                      r_abort,    // partial load abandoned
  input  logic [2*WIDTH*NT-1:0]     in_data,
  output logic                      r_last,     // current beat completes R
  output logic                      chan_valid,
  output logic [2*WIDTH*NRE-1:0]    core_r
);

  localparam int BW = (RBEATS > 1) ? $clog2(RBEATS) : 1;

  logic [BW-1:0] beat_cnt;
  logic [BW-1:0] beat_idx;

  // A beat arriving outside LOAD_R always restarts at beat 0.
  assign beat_idx = r_first ? '0 : beat_cnt;
  assign r_last   = (beat_idx == BW'(RBEATS - 1));

  // Beat position and channel-complete flag.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      beat_cnt   <= '0;
      chan_valid <= 1'b0;
    end else if (r_abort) begin
      beat_cnt   <= '0;
      chan_valid <= 1'b0;
    end else if (r_we) begin
      if (r_last) begin
        beat_cnt   <= '0;
        chan_valid <= 1'b1;
      end else begin
        beat_cnt   <= beat_idx + BW'(1);
        chan_valid <= 1'b0;
      end
    end
  end

  // Element file: each element listens only to the beat that carries it, so
  // unused slots of the final beat never land anywhere.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      core_r <= '0;
    end else if (r_we) begin
      for (int e = 0; e < NRE; e++) begin
        if (beat_idx == BW'(elem_beat(e, NT)))
          core_r[2*e*WIDTH +: 2*WIDTH] <= in_data[2*elem_slot(e, NT)*WIDTH +: 2*WIDTH];
      end
    end
  end

endmodule

// File: rtl/sd_frontend_ctrl.sv
// Sphere-decoder front end: accepts R and y beats, keeps one received vector
// waiting while another is in the core, launches the DFS/metric core and
// returns reordered hard decisions over a valid/ready port.
module sd_frontend_ctrl
  import sd_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NT       = 4,
  parameter int SYM_BITS = 3,
  parameter int CNT_W    = 16,
  localparam int NRE    = calc_nre(NT),
  localparam int RBEATS = calc_rbeats(NT)
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_is_channel,
  input  logic [2*WIDTH*NT-1:0]    InData,
  output logic                     core_start,
  output logic [2*WIDTH*NRE-1:0]   core_R,
  output logic [2*WIDTH*NT-1:0]    core_Y,
  input  logic                     core_done,
  input  logic [NT*SYM_BITS-1:0]   core_sym,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NT*SYM_BITS-1:0]   OutData,
  output logic                     err_abort,
  output logic                     err_nochan,
  output logic [CNT_W-1:0]         vec_count
);

  sd_state_e state, state_nx;

  logic                   pend_full;
  logic [2*WIDTH*NT-1:0]  pend_data;
  logic                   acc, acc_r, acc_d;
  logic                   launch, pend_wr;
  logic                   r_first, r_last, r_abort, chan_valid;
  logic [NT*SYM_BITS-1:0] sym_ord;

  // Channel beats wait for the core and the pending slot to be idle so R
  // never changes under a vector that has already been accepted.
  assign in_ready = in_is_channel ? (state != RUN && !pend_full)
                                  : (state == NOCHAN || state == LOAD_R || !pend_full);

  assign acc     = in_valid && in_ready;
  assign acc_r   = acc && in_is_channel;
  assign acc_d   = acc && !in_is_channel;
  assign r_first = (state != LOAD_R);
  assign r_abort = (state == LOAD_R) && acc_d;
  assign pend_wr = acc_d && (state == IDLE || state == RUN);
  assign launch  = (state == IDLE) && pend_full && chan_valid && (!out_valid || out_ready);

  // Core reports layer k at slot k; consumers want layer NT-1 in the LSBs.
  for (genvar k = 0; k < NT; k++) begin : g_ord
    assign sym_ord[(NT-1-k)*SYM_BITS +: SYM_BITS] = core_sym[k*SYM_BITS +: SYM_BITS];
  end

  sd_r_loader #(
    .WIDTH (WIDTH),
    .NT    (NT)
  ) u_loader (
    .Clk        (Clk),
    .Reset      (Reset),
    .r_we       (acc_r),
    .r_first    (r_first),
    .r_abort    (r_abort),
    .in_data    (InData),
    .r_last     (r_last),
    .chan_valid (chan_valid),
    .core_r     (core_R)
  );

  // State register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= NOCHAN;
    else        state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      NOCHAN: if (acc_r) state_nx = r_last ? IDLE : LOAD_R;
      LOAD_R: begin
        if (acc_r)      state_nx = r_last ? IDLE : LOAD_R;
        else if (acc_d) state_nx = NOCHAN;
      end
      IDLE: begin
        if (acc_r)       state_nx = r_last ? IDLE : LOAD_R;
        else if (launch) state_nx = RUN;
      end
      RUN:     if (core_done) state_nx = IDLE;
      default: state_nx = NOCHAN;
    endcase
  end

  // One-deep pending slot for a received vector.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pend_full <= 1'b0;
      pend_data <= '0;
    end else if (pend_wr) begin
      pend_full <= 1'b1;
      pend_data <= InData;
    end else if (launch) begin
      pend_full <= 1'b0;
    end
  end

  // Launch: hand the pending vector to the core with a single start pulse.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      core_start <= 1'b0;
      core_Y     <= '0;
    end else begin
      core_start <= launch;
      if (launch) core_Y <= pend_data;
    end
  end

  // Decision register and delivered-vector counter.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      out_valid <= 1'b0;
      OutData   <= '0;
      vec_count <= '0;
    end else begin
      if (state == RUN && core_done) begin
        out_valid <= 1'b1;
        OutData   <= sym_ord;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (out_valid && out_ready) vec_count <= vec_count + CNT_W'(1);
    end
  end

  // Protocol error pulses for dropped data beats.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      err_abort  <= 1'b0;
      err_nochan <= 1'b0;
    end else begin
      err_abort  <= r_abort;
      err_nochan <= (state == NOCHAN) && acc_d;
    end
  end

endmodule

// File: tb/tb_sd_frontend_ctrl.sv
// Directed bench for sd_frontend_ctrl: default NT=4 instance plus an NT=2,
// WIDTH=16 instance for the partial-last-beat geometry.
module tb_sd_frontend_ctrl;
  localparam int W = 32, NT = 4, SB = 3, CW = 16, NRE = 10;
  localparam int W2 = 16, NT2 = 2, SB2 = 2, NRE2 = 3;

  logic Clk = 1'b0, Reset = 1'b0;
  logic in_valid = 1'b0, in_is_channel = 1'b0, core_done = 1'b0, out_ready = 1'b0;
  logic [2*W*NT-1:0]   InData = '0;
  logic [NT*SB-1:0]    core_sym = '0;
  logic                in_ready, core_start, out_valid, err_abort, err_nochan;
  logic [2*W*NRE-1:0]  core_R;
  logic [2*W*NT-1:0]   core_Y;
  logic [NT*SB-1:0]    OutData;
  logic [CW-1:0]       vec_count;

  logic in_valid_b = 1'b0, in_is_channel_b = 1'b0, core_done_b = 1'b0, out_ready_b = 1'b0;
  logic [2*W2*NT2-1:0]  InData_b = '0;
  logic [NT2*SB2-1:0]   core_sym_b = '0;
  logic                 in_ready_b, core_start_b, out_valid_b, err_abort_b, err_nochan_b;
  logic [2*W2*NRE2-1:0] core_R_b;
  logic [2*W2*NT2-1:0]  core_Y_b;
  logic [NT2*SB2-1:0]   OutData_b;
  logic [CW-1:0]        vec_count_b;

  int checks = 0, errors = 0;

  localparam logic [255:0] YA = {4{64'hA5A5_0001_5A5A_0002}};
  localparam logic [255:0] YB = {4{64'h1234_5678_9ABC_DEF0}};
  localparam logic [255:0] YC = {4{64'h0F0F_1111_F0F0_2222}};
  localparam logic [255:0] YD = {4{64'hCAFE_0003_BEEF_0004}};
  localparam logic [255:0] YE = {4{64'h7777_0005_8888_0006}};

  sd_frontend_ctrl #(.WIDTH(W), .NT(NT), .SYM_BITS(SB), .CNT_W(CW)) u_dut (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_is_channel(in_is_channel), .InData(InData), .core_start(core_start),
    .core_R(core_R), .core_Y(core_Y), .core_done(core_done), .core_sym(core_sym),
    .out_valid(out_valid), .out_ready(out_ready), .OutData(OutData),
    .err_abort(err_abort), .err_nochan(err_nochan), .vec_count(vec_count)
  );

  sd_frontend_ctrl #(.WIDTH(W2), .NT(NT2), .SYM_BITS(SB2), .CNT_W(CW)) u_dut2 (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_is_channel(in_is_channel_b), .InData(InData_b), .core_start(core_start_b),
    .core_R(core_R_b), .core_Y(core_Y_b), .core_done(core_done_b), .core_sym(core_sym_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .OutData(OutData_b),
    .err_abort(err_abort_b), .err_nochan(err_nochan_b), .vec_count(vec_count_b)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  // Element e: real = base+e+1, imag = base+256+e.
  function automatic logic [2*W*NRE-1:0] exp_r(input int base);
    logic [2*W*NRE-1:0] r;
    r = '0;
    for (int e = 0; e < NRE; e++) begin
      r[2*e*W +: W]     = W'(base + e + 1);
      r[(2*e+1)*W +: W] = W'(base + 256 + e);
    end
    return r;
  endfunction

  task automatic send_r(input int b, input int base);
    logic [2*W*NT-1:0] d;
    d = '0;
    for (int j = 0; j < NT; j++) begin
      d[2*j*W +: W]     = W'(base + b*NT + j + 1);
      d[(2*j+1)*W +: W] = W'(base + 256 + b*NT + j);
    end
    in_valid = 1'b1; in_is_channel = 1'b1; InData = d;
    #1 check("r_beat_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_y(input logic [255:0] y);
    in_valid = 1'b1; in_is_channel = 1'b0; InData = y;
    #1 check("y_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    check("rst_start", core_start, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_outdata", OutData, 0);
    check("rst_vec_count", vec_count, 0);
    check("rst_err_abort", err_abort, 0);
    check("rst_core_r", core_R, 0);
    Reset = 1'b1;
    in_is_channel = 1'b1;
    #1 check("nochan_chan_ready", in_ready, 1);
    tick();

    // Basic decode: 3 R beats, one y, core_done 20 cycles after start
    send_r(0, 0); send_r(1, 0); send_r(2, 0);
    check("core_r_load", core_R, exp_r(0));
    send_y(YA);
    check("start_not_yet", core_start, 0);
    tick();
    check("start_pulse", core_start, 1);
    check("core_y", core_Y, YA);
    tick();
    check("start_one_cycle", core_start, 0);
    repeat (18) tick();
    core_done = 1'b1; core_sym = {3'd1, 3'd2, 3'd3, 3'd4};
    tick();
    core_done = 1'b0;
    check("out_valid", out_valid, 1);
    check("outdata_order", OutData, 12'b100_011_010_001);
    check("vec_before_ready", vec_count, 0);
    out_ready = 1'b1;
    tick();
    check("vec_count_1", vec_count, 1);
    check("out_valid_drained", out_valid, 0);
    out_ready = 1'b0;

    // Back-to-back vectors with stalled output
    in_valid = 1'b1; in_is_channel = 1'b0; InData = YA;
    #1 check("bb_a_ready", in_ready, 1);
    tick();
    InData = YB;
    #1 check("bb_b_stall", in_ready, 0);
    tick();
    check("bb_b_ready_run", in_ready, 1);
    check("bb_core_y_a", core_Y, YA);
    tick();
    InData = YC;
    #1 check("bb_c_stall", in_ready, 0);
    core_done = 1'b1; core_sym = {3'd7, 3'd0, 3'd5, 3'd2};
    tick();
    core_done = 1'b0;
    check("bb_out_a", OutData, {3'd2, 3'd5, 3'd0, 3'd7});
    repeat (3) tick();
    check("bb_c_still_stalled", in_ready, 0);
    check("bb_out_held", out_valid, 1);
    check("bb_no_launch", core_start, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bb_vec_2", vec_count, 2);
    check("bb_launch_b", core_start, 1);
    check("bb_core_y_b", core_Y, YB);
    check("bb_c_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    tick();
    core_done = 1'b1; core_sym = {3'd6, 3'd6, 3'd1, 3'd3};
    tick();
    core_done = 1'b0;
    check("bb_out_b", OutData, {3'd3, 3'd1, 3'd6, 3'd6});
    out_ready = 1'b1;
    tick();
    check("bb_vec_3", vec_count, 3);
    check("bb_core_y_c", core_Y, YC);
    core_done = 1'b1; core_sym = {3'd0, 3'd4, 3'd7, 3'd1};
    tick();
    core_done = 1'b0;
    check("bb_out_c", OutData, {3'd1, 3'd7, 3'd4, 3'd0});
    tick();
    check("bb_vec_4", vec_count, 4);
    out_ready = 1'b0;

    // Aborted channel load and data without a channel
    send_r(0, 0);
    send_y(YD);
    check("abort_pulse", err_abort, 1);
    check("abort_no_nochan", err_nochan, 0);
    check("abort_no_start", core_start, 0);
    tick();
    check("abort_one_cycle", err_abort, 0);
    send_y(YD);
    check("nochan_pulse", err_nochan, 1);
    tick();
    check("nochan_one_cycle", err_nochan, 0);
    check("nochan_no_start", core_start, 0);
    check("nochan_no_out", out_valid, 0);

    // Channel beat offered during RUN, then reload
    send_r(0, 0); send_r(1, 0); send_r(2, 0);
    send_y(YD);
    tick();
    check("run_start", core_start, 1);
    in_valid = 1'b1; in_is_channel = 1'b1; InData = '1;
    #1 check("run_chan_stall", in_ready, 0);
    repeat (3) tick();
    check("run_chan_stall_held", in_ready, 0);
    check("run_core_r_frozen", core_R, exp_r(0));
    in_valid = 1'b0;
    core_done = 1'b1; core_sym = {3'd7, 3'd0, 3'd5, 3'd2}; out_ready = 1'b1;
    tick();
    core_done = 1'b0;
    tick();
    out_ready = 1'b0;
    check("run_vec_5", vec_count, 5);
    send_r(0, 1000); send_r(1, 1000); send_r(2, 1000);
    check("reload_core_r", core_R, exp_r(1000));
    send_y(YE);
    tick();
    check("reload_start", core_start, 1);
    check("reload_core_y", core_Y, YE);

    // Reset in the middle of RUN; late core_done ignored
    Reset = 1'b0;
    #1;
    check("mid_rst_start", core_start, 0);
    check("mid_rst_core_r", core_R, 0);
    check("mid_rst_core_y", core_Y, 0);
    check("mid_rst_vec", vec_count, 0);
    check("mid_rst_outdata", OutData, 0);
    core_done = 1'b1; core_sym = {3'd6, 3'd6, 3'd1, 3'd3};
    tick();
    Reset = 1'b1;
    tick();
    core_done = 1'b0;
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_outdata", OutData, 0);
    in_is_channel = 1'b1;
    #1 check("post_rst_nochan_ready", in_ready, 1);

    // NT=2, WIDTH=16: last beat slot 1 is ignored
    in_valid_b = 1'b1; in_is_channel_b = 1'b1;
    InData_b = {16'h0022, 16'h0012, 16'h0021, 16'h0011};
    tick();
    InData_b = {16'hBEEF, 16'hDEAD, 16'h0023, 16'h0013};
    tick();
    in_valid_b = 1'b0;
    check("nt2_core_r", core_R_b, {16'h0023, 16'h0013, 16'h0022, 16'h0012, 16'h0021, 16'h0011});
    in_valid_b = 1'b1; in_is_channel_b = 1'b0; InData_b = 64'h0102_0304_0506_0708;
    tick();
    in_valid_b = 1'b0;
    tick();
    check("nt2_start", core_start_b, 1);
    check("nt2_core_y", core_Y_b, 64'h0102_0304_0506_0708);
    core_done_b = 1'b1; core_sym_b = 4'b10_01;
    tick();
    core_done_b = 1'b0;
    check("nt2_out_valid", out_valid_b, 1);
    check("nt2_outdata", OutData_b, 4'b01_10);
    out_ready_b = 1'b1;
    tick();
    check("nt2_vec_count", vec_count_b, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
